// File: rtl/gf_chien_search_pkg.sv
// gf_chien_pkg
//   Shared definitions for the Chien-search block: FSM state constants,
//   the field-size helper N = 2^M - 1 and the single-step multiply by alpha
//   over the trinomial field x^M + x^ALPHA + 1.
//   No ports (package).
package gf_chien_pkg;

    // Widest field the alpha-step helper supports.
    localparam int MAX_M = 16;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_EVAL = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // Number of nonzero field elements, i.e. the search length.
    function automatic int chien_n(input int m);
        return (2 ** m) - 1;
    endfunction

    // One LFSR step: shift up, feed the old MSB back into bit 0 and into
    // the middle tap. Operands live in the low m bits of a MAX_M-wide word.
    function automatic logic [MAX_M-1:0] mul_alpha(input logic [MAX_M-1:0] b,
                                                   input int m,
                                                   input int alpha);
        logic [MAX_M-1:0] one;
        logic [MAX_M-1:0] mask;
        logic [MAX_M-1:0] tap;
        logic             msb;
        one  = MAX_M'(1);
        mask = (one << m) - one;
        msb  = |(b & (one << (m - 1)));
        tap  = one | (one << alpha);
        return ((b << 1) & mask) ^ (msb ? tap : '0);
    endfunction

endpackage

// File: rtl/gf_chien_search_if.sv
// gf_chien_search_if
//   Request/result bundle of the Chien search.
//   start, sigma          : request (driver -> search)
//   ready                 : search idle, start will be taken
//   loc_valid, loc        : per-cycle root report, no back-pressure
//   done, root_cnt, fail  : end-of-search status (root_cnt/fail held)
interface gf_chien_search_if #(
    parameter int PARAM_M = 4,
    parameter int PARAM_T = 2
);
    localparam int RC_W = $clog2(PARAM_T + 1);

    logic                           start;
    logic [(PARAM_T+1)*PARAM_M-1:0] sigma;
    logic                           ready;
    logic                           loc_valid;
    logic [PARAM_M-1:0]             loc;
    logic                           done;
    logic [RC_W-1:0]                root_cnt;
    logic                           fail;

    modport master (
        output start, sigma,
        input  ready, loc_valid, loc, done, root_cnt, fail
    );

    modport slave (
        input  start, sigma,
        output ready, loc_valid, loc, done, root_cnt, fail
    );

endinterface

// File: rtl/gf_chien_search_mul_alpha_pow.sv
// gf_mul_alpha_pow
//   Combinational multiply by alpha^PARAM_POW: PARAM_POW chained LFSR steps.
//   in_i  : field element, polynomial basis
//   out_o : in_i * alpha^PARAM_POW
module gf_mul_alpha_pow
    import gf_chien_pkg::*;
#(
    parameter int PARAM_M     = 4,
    parameter int PARAM_ALPHA = 1,
    parameter int PARAM_POW   = 1
) (
    input  logic [PARAM_M-1:0] in_i,
    output logic [PARAM_M-1:0] out_o
);

    logic [PARAM_M-1:0] stg [PARAM_POW+1];

    always_comb begin
        stg[0] = in_i;
        for (int k = 0; k < PARAM_POW; k++) begin
            stg[k+1] = PARAM_M'(mul_alpha(MAX_M'(stg[k]), PARAM_M, PARAM_ALPHA));
        end
    end

    assign out_o = stg[PARAM_POW];

endmodule

// File: rtl/gf_chien_search.sv
// gf_chien_search
//   Sequential Chien search: evaluates sigma(x) at alpha^0..alpha^(N-1), one
//   point per cycle, and reports each root as error location (N-i) mod N.
//   clk       : clock, rising edge
//   rst       : synchronous reset, active low
//   bus.slave : start/sigma in; ready, loc_valid, loc, done, root_cnt, fail out
module gf_chien_search
    import gf_chien_pkg::*;
#(
    parameter int PARAM_M     = 4,
    parameter int PARAM_ALPHA = 1,
    parameter int PARAM_T     = 2
) (
    input  logic clk,
    input  logic rst,
    gf_chien_search_if.slave bus
);

    localparam int N    = chien_n(PARAM_M);
    localparam int RC_W = $clog2(PARAM_T + 1);

    localparam logic [PARAM_M-1:0] CNT_LAST = PARAM_M'(N);
    localparam logic [RC_W-1:0]    RC_MAX   = '1;

    state_t                        state_q, state_d;
    logic [PARAM_T:0][PARAM_M-1:0] reg_q, reg_d, reg_step;
    logic [PARAM_M-1:0]            cnt_q, cnt_d;
    logic [RC_W-1:0]               root_cnt_q, root_cnt_d;
    logic [RC_W-1:0]               deg_q, deg_d;
    logic                          zero_q, zero_d;
    logic                          fail_q, fail_d;

    logic [PARAM_M-1:0] sum;
    logic [RC_W-1:0]    sigma_deg;
    logic               sigma_zero;
    logic               hit;
    logic               fail_now;

    // Term j of sigma(alpha^i) is sigma_j * alpha^(i*j): advancing i by one
    // multiplies each register by alpha^j. The constant term never moves.
    assign reg_step[0] = reg_q[0];

    for (genvar j = 1; j <= PARAM_T; j++) begin : g_step
        gf_mul_alpha_pow #(
            .PARAM_M    (PARAM_M),
            .PARAM_ALPHA(PARAM_ALPHA),
            .PARAM_POW  (j)
        ) u_mul (
            .in_i (reg_q[j]),
            .out_o(reg_step[j])
        );
    end

    always_comb begin
        sum = '0;
        for (int j = 0; j <= PARAM_T; j++) begin
            sum = sum ^ reg_q[j];
        end
    end

    // Degree of the incoming locator; a zero polynomial reports degree 0.
    always_comb begin
        sigma_deg  = '0;
        sigma_zero = 1'b1;
        for (int j = 0; j <= PARAM_T; j++) begin
            if (bus.sigma[j*PARAM_M +: PARAM_M] != '0) begin
                sigma_deg  = RC_W'(j);
                sigma_zero = 1'b0;
            end
        end
    end

    assign hit      = (state_q == S_EVAL) && (sum == '0);
    assign fail_now = zero_q || (root_cnt_q != deg_q);

    always_comb begin
        state_d    = state_q;
        reg_d      = reg_q;
        cnt_d      = cnt_q;
        root_cnt_d = root_cnt_q;
        deg_d      = deg_q;
        zero_d     = zero_q;
        fail_d     = fail_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    for (int j = 0; j <= PARAM_T; j++) begin
                        reg_d[j] = bus.sigma[j*PARAM_M +: PARAM_M];
                    end
                    cnt_d      = '0;
                    root_cnt_d = '0;
                    deg_d      = sigma_deg;
                    zero_d     = sigma_zero;
                    fail_d     = 1'b0;
                    state_d    = sigma_zero ? S_DONE : S_EVAL;
                end
            end
            S_EVAL: begin
                reg_d = reg_step;
                cnt_d = cnt_q + 1'b1;
                if (hit && (root_cnt_q != RC_MAX)) begin
                    root_cnt_d = root_cnt_q + 1'b1;
                end
                if (cnt_q == CNT_LAST - 1'b1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                fail_d  = fail_now;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            reg_q      <= '0;
            cnt_q      <= '0;
            root_cnt_q <= '0;
            deg_q      <= '0;
            zero_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_q      <= reg_d;
            cnt_q      <= cnt_d;
            root_cnt_q <= root_cnt_d;
            deg_q      <= deg_d;
            zero_q     <= zero_d;
            fail_q     <= fail_d;
        end
    end

    assign bus.ready     = (state_q == S_IDLE);
    assign bus.loc_valid = hit;
    // alpha^i is a root of sigma, so the error sits at alpha^-i = alpha^(N-i).
    assign bus.loc       = !hit ? '0 : ((cnt_q == '0) ? '0 : (CNT_LAST - cnt_q));
    assign bus.done      = (state_q == S_DONE);
    assign bus.root_cnt  = root_cnt_q;
    // fail is computed live in the done cycle and held afterwards.
    assign bus.fail      = (state_q == S_DONE) ? fail_now : fail_q;

endmodule

// File: doc/gf_chien_search.md
# gf_chien_search

Sequential Chien-search stage that evaluates an error-locator polynomial sigma(x) over GF(2^PARAM_M) at every field point alpha^i, i = 0..N-1, where N = 2^PARAM_M-1. The field is the trinomial field x^M + x^ALPHA + 1, the same field our LFSR alpha-multiplier stepping uses. The block sits downstream of the locator/alpha-multiplier datapath. It consumes the locator coefficients and streams out error locations to the correction stage, one field point per cycle.

## Interface
Parameters:
- PARAM_M, 4, field degree m
- PARAM_ALPHA, 1, middle tap of x^M + x^ALPHA + 1; 1 <= ALPHA < M
- PARAM_T, 2, maximum locator degree, i.e. the correction capability

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  request to search; accepted only when ready=1
- sigma  in  (T+1)*M  coefficient j at [j*M +: M], polynomial basis
- ready  out  1  idle and able to accept start
- loc_valid  out  1  a root was found this cycle
- loc  out  M  error location (N-i) mod N of the root alpha^i
- done  out  1  one-cycle pulse at end of search
- root_cnt  out  $clog2(T+1)  roots found; held until the next accepted start
- fail  out  1  valid with done; held with root_cnt

## Operation
- State machine: IDLE, EVAL, DONE.
- IDLE
  - ready=1.
  - start=1 loads reg[j] <= sigma_j, cnt <= 0, root_cnt <= 0, and latches deg (index of the highest nonzero coefficient).
  - Next state is EVAL if sigma != 0. If sigma == 0, deg := 0 and next state is DONE.
- EVAL, each cycle:
  - sum = XOR of all reg[j].
  - If sum == 0: loc_valid=1, loc = (cnt==0) ? 0 : N-cnt, and root_cnt increments, saturating at 2^width-1.
  - reg[j] <= reg[j]·alpha^j. reg[0] is constant.
  - cnt <= cnt+1.
  - When cnt == N-1, go to DONE after this evaluation.
- DONE
  - done=1 for one cycle.
  - fail = (sigma was zero) OR (root_cnt != deg).
  - Go to IDLE.
- Multiply by alpha is one LFSR step: b'[0]=b[M-1]; b'[ALPHA]=b[ALPHA-1]^b[M-1]; all other b'[i]=b[i-1]. Multiply by alpha^j is that step applied j times, combinationally.
- start while ready=0 is ignored. It has no effect on any output.
- loc and loc_valid are combinational from the registers in EVAL. loc=0 and loc_valid=0 outside EVAL.

## Timing
- Reset (rst=0 at an edge) forces:
  - state=IDLE
  - ready=1 from the following cycle
  - loc_valid=0, loc=0, done=0, root_cnt=0, fail=0
  - all reg and cnt = 0
- Reset mid-search aborts immediately: no done pulse and no further loc_valid.
- Cycle numbering from an accepted start at cycle 0:
  - evaluations of alpha^0..alpha^(N-1) occur in cycles 1..N
  - done is in cycle N+1
  - ready=1 again in cycle N+2
- Zero-sigma path: done in cycle 1, ready in cycle 2.
- Throughput is one search per N+2 cycles. There is no back-pressure on loc_valid; the consumer must accept every cycle.

## Structure
- Package gf_chien_pkg holds:
  - the state enum (IDLE, EVAL, DONE)
  - the constant N = 2**M-1
  - the function for a single-step alpha multiply, parameterised by M and ALPHA
- Sub-module gf_mul_alpha_pow #(PARAM_M, PARAM_ALPHA, PARAM_POW): purely combinational multiply by alpha^POW. It is instantiated for j = 1..T in a generate loop.
- The top level contains the FSM, cnt, the coefficient registers, the XOR-reduction, and root counting.
- Target size is roughly 150-250 lines of RTL.

## Test plan
All scenarios use M=4, ALPHA=1, T=2, N=15.
- Single error: sigma=12'h081 (1 + alpha^3·x).
  - Required: exactly one loc_valid, in cycle 13 (i=12), with loc=3.
  - Required: done in cycle 16, root_cnt=1, fail=0.
- Two errors: sigma=12'h671 (coefficients 1, 7, 6).
  - Required: loc_valid in cycle 1 (loc=0) and in cycle 11 (loc=5).
  - Required: root_cnt=2, fail=0.
- Repeated root: sigma=12'h101 (1 + x^2).
  - Required: a single loc_valid in cycle 1 with loc=0.
  - Required: root_cnt=1, deg=2, fail=1.
- Zero polynomial: sigma=12'h000.
  - Required: no loc_valid, done in cycle 1, fail=1, root_cnt=0, ready in cycle 2.
- Busy/reset: pulse start with a new sigma in cycle 5 of a search, then assert rst=0 in cycle 8.
  - Required: the cycle-5 start has no effect.
  - Required: the cycle following the rst=0 edge has all outputs at reset values, ready=1, and no done.
  - Required: a fresh start then reproduces the single-error result exactly.
